// File: rtl/object_rom_arbiter.sv
// Round-robin arbiter sharing one object ROM reader port between NUM_REQ sprite pipelines.
// One lookup is accepted per cycle. The granted request's row/col/index are registered
// onto the ROM reader inputs. A tag pipeline, ROM_LAT+1 stages deep, tracks each lookup
// in flight. It returns the colour to the originating requester with a transparency flag.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is the one-hot grant)
//   req_row/col/index     packed per-requester lookup fields (requester i at [W*i +: W])
//   rom_row/col/index     registered address and index to the ROM reader
//   rom_color             colour from the reader, ROM_LAT cycles after the address
//   rsp_valid/id/color    single-cycle response, in issue order
//   rsp_transparent       colour is TRANSPARENT_COLOR or the request index was 0
module object_rom_arbiter #(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned ID_W              = 2,
    parameter int unsigned ROM_LAT           = 1,
    parameter logic [11:0] TRANSPARENT_COLOR = 12'hF0F
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*10-1:0] req_row,
    input  logic [NUM_REQ*10-1:0] req_col,
    input  logic [NUM_REQ*3-1:0]  req_index,
    output logic [9:0]            rom_row,
    output logic [9:0]            rom_col,
    output logic [2:0]            rom_index,
    input  logic [11:0]           rom_color,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [11:0]           rsp_color,
    output logic                  rsp_transparent
);

    localparam int unsigned Depth = ROM_LAT + 1;

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            grant_any;
    logic [ID_W-1:0] grant_id;
    logic [9:0]      grant_row, grant_col;
    logic [2:0]      grant_index;

    logic [Depth-1:0]           tag_valid_q;
    logic [Depth-1:0]           tag_zero_q;
    logic [Depth-1:0][ID_W-1:0] tag_id_q;

    // Two passes give the rotated search order: first requesters at or above ptr,
    // then anything still valid below it.
    always_comb begin
        grant_any   = 1'b0;
        grant_id    = '0;
        grant_row   = '0;
        grant_col   = '0;
        grant_index = '0;
        req_ready   = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!grant_any && req_valid[j] && (j >= 32'(ptr_q))) begin
                grant_any   = 1'b1;
                grant_id    = ID_W'(j);
                grant_row   = req_row[j*10 +: 10];
                grant_col   = req_col[j*10 +: 10];
                grant_index = req_index[j*3 +: 3];
                req_ready[j] = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!grant_any && req_valid[j]) begin
                grant_any   = 1'b1;
                grant_id    = ID_W'(j);
                grant_row   = req_row[j*10 +: 10];
                grant_col   = req_col[j*10 +: 10];
                grant_index = req_index[j*3 +: 3];
                req_ready[j] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Idle cycles force index 0 so the reader returns colour 0; row/col just hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_row   <= '0;
            rom_col   <= '0;
            rom_index <= '0;
        end else if (grant_any) begin
            rom_row   <= grant_row;
            rom_col   <= grant_col;
            rom_index <= grant_index;
        end else begin
            rom_index <= '0;
        end
    end

    // Stage 0 lines up with the registered ROM address; the last stage lines up with
    // the colour coming back from the reader.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid_q <= '0;
            tag_zero_q  <= '0;
            tag_id_q    <= '0;
        end else begin
            tag_valid_q <= {tag_valid_q[Depth-2:0], grant_any};
            tag_zero_q  <= {tag_zero_q[Depth-2:0], (grant_index == 3'd0)};
            tag_id_q    <= {tag_id_q[Depth-2:0], grant_id};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid       <= 1'b0;
            rsp_id          <= '0;
            rsp_color       <= '0;
            rsp_transparent <= 1'b0;
        end else if (tag_valid_q[Depth-1]) begin
            rsp_valid       <= 1'b1;
            rsp_id          <= tag_id_q[Depth-1];
            rsp_color       <= rom_color;
            rsp_transparent <= (rom_color == TRANSPARENT_COLOR) | tag_zero_q[Depth-1];
        end else begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_object_rom_arbiter.sv
module tb_object_rom_arbiter;

    localparam int N       = 4;
    localparam int ID_W    = 2;
    localparam int ROM_LAT = 1;
    localparam logic [11:0] TC = 12'hF0F;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*10-1:0]   req_row, req_col;
    logic [N*3-1:0]    req_index;
    logic [9:0]        rom_row, rom_col;
    logic [2:0]        rom_index;
    logic [11:0]       rom_color;
    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [11:0]       rsp_color;
    logic              rsp_transparent;

    always #5 clk = ~clk;

    object_rom_arbiter #(
        .NUM_REQ(N), .ID_W(ID_W), .ROM_LAT(ROM_LAT), .TRANSPARENT_COLOR(TC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_col(req_col), .req_index(req_index),
        .rom_row(rom_row), .rom_col(rom_col), .rom_index(rom_index),
        .rom_color(rom_color),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_color(rsp_color),
        .rsp_transparent(rsp_transparent)
    );

    // ROM reader model: index 0 reads nothing, index 4 is see-through.
    function automatic logic [11:0] rom_fn(input logic [9:0] r, input logic [9:0] c,
                                           input logic [2:0] i);
        logic [11:0] v;
        if (i == 3'd0) return 12'h000;
        if (i == 3'd4) return TC;
        v = {2'b00, r} ^ {c[5:0], 6'b0} ^ {i, i, i, i};
        return v;
    endfunction

    logic [11:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_fn(rom_row, rom_col, rom_index);
        for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_color = rom_pipe[ROM_LAT-1];

    typedef struct {
        int         id;
        int         cyc;
        logic [9:0] row;
        logic [9:0] col;
        logic [2:0] idx;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          m_ptr = 0;
    logic [9:0]  exp_rom_row = '0, exp_rom_col = '0;
    logic [2:0]  exp_rom_index = '0;
    int          last_id = 0;
    logic [11:0] last_color = '0;
    logic        last_tr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = 0;
        exp_rom_row = '0;
        exp_rom_col = '0;
        exp_rom_index = '0;
        last_id = 0;
        last_color = '0;
        last_tr = 1'b0;
    endtask

    task automatic check_outputs();
        exp_t e;
        check_eq("rom_row", 32'(rom_row), 32'(exp_rom_row));
        check_eq("rom_col", 32'(rom_col), 32'(exp_rom_col));
        check_eq("rom_index", 32'(rom_index), 32'(exp_rom_index));
        if (q.size() != 0 && q[0].cyc + 2 + ROM_LAT == cyc) begin
            e = q.pop_front();
            last_id = e.id;
            last_color = rom_fn(e.row, e.col, e.idx);
            last_tr = (last_color == TC) || (e.idx == 3'd0);
            check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
        end else begin
            check_eq("rsp_valid", 32'(rsp_valid), 32'd0);
        end
        check_eq("rsp_id", 32'(rsp_id), 32'(last_id));
        check_eq("rsp_color", 32'(rsp_color), 32'(last_color));
        check_eq("rsp_transparent", 32'(rsp_transparent), 32'(last_tr));
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic drive(input logic [N-1:0] mask);
        req_valid = mask;
        for (int i = 0; i < N; i++) begin
            req_row[i*10 +: 10] = 10'($urandom);
            req_col[i*10 +: 10] = 10'($urandom);
            req_index[i*3 +: 3] = 3'($urandom);
        end
    endtask

    // Grant is the first valid requester in rotated order starting at the pointer.
    task automatic end_cycle();
        int g;
        logic [N-1:0] exp_ready;
        exp_t e;
        #1;
        g = -1;
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (g < 0 && req_valid[c]) g = c;
        end
        exp_ready = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            e.id  = g;
            e.cyc = cyc;
            e.row = req_row[g*10 +: 10];
            e.col = req_col[g*10 +: 10];
            e.idx = req_index[g*3 +: 3];
            q.push_back(e);
            exp_rom_row = e.row;
            exp_rom_col = e.col;
            exp_rom_index = e.idx;
            m_ptr = (g + 1) % N;
        end else begin
            exp_rom_index = '0;
        end
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    endtask

    task automatic step(input logic [N-1:0] mask);
        begin_cycle();
        drive(mask);
        end_cycle();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        req_valid = '0;
        #1;
        model_reset();
        check_outputs();
        check_eq("req_ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        req_valid = '0;
        req_row = '0;
        req_col = '0;
        req_index = '0;
        #1 reset_n = 1'b0;
        #1;
        check_outputs();
        check_eq("req_ready_reset", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single request from requester 2.
        drive(4'b0100);
        req_row[29:20] = 10'd5;
        req_col[29:20] = 10'd7;
        req_index[8:6] = 3'd3;
        end_cycle();
        for (int i = 0; i < 4; i++) step('0);

        // All requesters continuously valid.
        for (int i = 0; i < 8; i++) step(4'b1111);
        for (int i = 0; i < 4; i++) step('0);

        // Move ptr to 2, then requesters 1 and 3 alternate.
        step(4'b0010);
        for (int i = 0; i < 4; i++) step(4'b1010);

        // Random traffic.
        for (int i = 0; i < 300; i++) step(4'($urandom));

        // Reset with lookups in flight.
        for (int i = 0; i < 4; i++) step(4'b1111);
        begin_cycle();
        pulse_reset();
        drive(4'b1111);
        end_cycle();
        for (int i = 0; i < 40; i++) step(4'($urandom));

        // Idle period, then check the pointer resumes where it left off.
        for (int i = 0; i < 10; i++) step('0);
        for (int i = 0; i < 3; i++) step(4'b1111);
        for (int i = 0; i < 6; i++) step('0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
